frame_buffer_db: RTL and testbench
==================================

Name: frame_buffer_db

Overview:
- Parametrised, double-buffered pixel frame buffer for the game renderer.
- The drawing logic writes pixels by (x,y) into the back buffer; display/collision logic reads the front buffer through NUM_RD independent registered read ports.
- A built-in clear engine fills the back buffer with one colour, one pixel per cycle.
- A swap request exchanges front and back buffers, deferred until any clear in progress completes.

Parameters:
- W, 120, frame width in pixels
- H, 60, frame height in pixels
- PIX_W, 3, bits per pixel (colour index)
- NUM_RD, 2, number of independent read ports
- XW, 7, x coordinate width; must satisfy 2^XW >= W
- YW, 6, y coordinate width; must satisfy 2^YW >= H

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  pixel write strobe
- wr_x  in  XW  write x
- wr_y  in  YW  write y
- wr_data  in  PIX_W  write colour
- clr_req  in  1  start clear of back buffer (pulse)
- clr_color  in  PIX_W  fill colour, sampled with clr_req
- swap_req  in  1  request front/back exchange (pulse)
- rd_x  in  NUM_RD*XW  packed read x, port i at [i*XW +: XW]
- rd_y  in  NUM_RD*YW  packed read y
- rd_data  out  NUM_RD*PIX_W  packed read colour, registered
- busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse on the last clear write
- front_sel  out  1  current front bank (0/1)

Behaviour:
- Storage: 2*W*H entries of PIX_W bits.
  - Linear address = bank*W*H + y*W + x.
  - Back bank = ~front_sel.
- Reset: front_sel=0, busy=0, clr_done=0, rd_data=0, swap_pending=0, FSM=IDLE.
  - RAM contents are not cleared by rst.
  - rst during CLEAR aborts the clear; the partially cleared region keeps its values.
- Write (IDLE only): on wr_en with wr_x<W and wr_y<H, write wr_data to the back bank at the next clock edge.
  - Out-of-range writes are silently dropped.
  - wr_en during CLEAR is ignored.
- Reads:
  - rd_data[i] is valid 1 cycle after rd_x/rd_y[i] are presented, and always comes from the front bank as of the presenting cycle.
  - Out-of-range coordinates return 0.
  - Reads never stall.
  - The front bank is never written, so there are no read/write collisions.
- FSM states IDLE, CLEAR:
  - IDLE -> CLEAR on clr_req. Latch clr_color; clear counter=0; busy=1 from the next cycle.
  - CLEAR: each cycle write the latched colour to back[counter], then increment the counter.
  - CLEAR -> IDLE on the cycle counter=W*H-1 is written. clr_done=1 that cycle; busy=0 the next cycle.
  - clr_req in CLEAR is ignored.
  - Clear duration is exactly W*H cycles (7200 at defaults).
- Swap:
  - In IDLE without clr_req, swap_req toggles front_sel at the next edge.
  - swap_req in CLEAR, or coincident with clr_req in IDLE, sets swap_pending. front_sel toggles at the edge following the clr_done cycle; swap_pending then clears.
  - Repeated swap_req while pending collapses to one swap.
- Simultaneous events in IDLE:
  - wr_en + clr_req: the write takes effect; the clear starts and overwrites it.
  - wr_en + swap_req: the write lands in the old back bank, which becomes front after the swap.

Decomposition:
- Shared package (fb_pkg):
  - pixel typedef (PIX_W bits)
  - FSM state enum {IDLE, CLEAR}
  - default W/H constants, also used by the renderer and the VGA scan module
- One natural sub-module: fb_addr_map, which performs (x,y,bank) -> linear address plus the in-range flag. Instantiate it once for the write port and once per read port.

Test Plan:
- Reset, then write (5,3)=6 in back bank 1, swap_req, read (5,3) on port 0 -> rd_data[0]=6 one cycle later; front_sel=1.
- Write (120,0)=7 and (0,60)=7 -> no RAM change. Read (120,0) -> 0.
- clr_req with clr_color=2 -> busy=1 for exactly 7200 cycles and clr_done pulses once. After a swap, every sampled pixel reads 2, including (0,0) and (119,59).
- swap_req at clear cycle 100 -> front_sel unchanged until the cycle after clr_done, then toggles once. A second swap_req during the clear adds no extra toggle.
- wr_en (10,10)=5 during CLEAR -> ignored; after clear and swap, (10,10) reads the clear colour.
- Ports 0 and 1 read different pixels in the same cycle -> both correct independently.
- rst asserted mid-clear -> busy=0, front_sel=0, rd_data=0 next cycle; a subsequent clr_req restarts the clear from counter 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and default frame geometry, also used by the
// renderer and the VGA scan module.
package fb_pkg;

  localparam int FB_W     = 120;
  localparam int FB_H     = 60;
  localparam int FB_PIX_W = 3;

  typedef logic [FB_PIX_W-1:0] pixel_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_addr_map.sv
// Maps (x, y, bank) to a linear RAM address and flags whether (x, y) lies
// inside the frame.
module fb_addr_map #(
  parameter int W  = 120,
  parameter int H  = 60,
  parameter int XW = 7,
  parameter int YW = 6,
  parameter int AW = 14
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          bank,
  output logic [AW-1:0] addr,
  output logic          in_range
);

  localparam logic [AW-1:0] W_A    = AW'(W);
  localparam logic [AW-1:0] BANK_A = AW'(W * H);

  always_comb begin
    in_range = (32'(x) < W) && (32'(y) < H);
    addr     = (bank ? BANK_A : '0) + AW'(y) * W_A + AW'(x);
  end

endmodule

// File: rtl/frame_buffer_db.sv
// Double-buffered pixel frame buffer: back-bank writes plus a one-pixel-per-
// cycle clear engine, NUM_RD registered front-bank read ports, deferred swap.
module frame_buffer_db
  import fb_pkg::*;
#(
  parameter int W      = FB_W,
  parameter int H      = FB_H,
  parameter int PIX_W  = FB_PIX_W,
  parameter int NUM_RD = 2,
  parameter int XW     = 7,
  parameter int YW     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [XW-1:0]           wr_x,
  input  logic [YW-1:0]           wr_y,
  input  logic [PIX_W-1:0]        wr_data,
  input  logic                    clr_req,
  input  logic [PIX_W-1:0]        clr_color,
  input  logic                    swap_req,
  input  logic [NUM_RD*XW-1:0]    rd_x,
  input  logic [NUM_RD*YW-1:0]    rd_y,
  output logic [NUM_RD*PIX_W-1:0] rd_data,
  output logic                    busy,
  output logic                    clr_done,
  output logic                    front_sel
);

  localparam int NPIX = W * H;
  localparam int AW   = $clog2(2 * NPIX);
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

  logic [PIX_W-1:0] mem [0:2*NPIX-1];

  fb_state_e               state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PIX_W-1:0]        clr_color_q, clr_color_d;
  logic                    front_q, front_d;
  logic                    pending_q, pending_d;
  logic                    done_q, done_d;
  logic [NUM_RD*PIX_W-1:0] rd_data_q, rd_data_d;

  logic [AW-1:0]    wr_addr, clr_addr, mem_addr;
  logic             wr_ok, mem_we;
  logic [PIX_W-1:0] mem_wdata;
  logic [AW-1:0]    rd_addr [NUM_RD];
  logic             rd_ok   [NUM_RD];

  fb_addr_map #(.W(W), .H(H), .XW(XW), .YW(YW), .AW(AW)) u_wr_map (
    .x(wr_x), .y(wr_y), .bank(~front_q), .addr(wr_addr), .in_range(wr_ok)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_map
    fb_addr_map #(.W(W), .H(H), .XW(XW), .YW(YW), .AW(AW)) u_rd_map (
      .x(rd_x[i*XW +: XW]), .y(rd_y[i*YW +: YW]), .bank(front_q),
      .addr(rd_addr[i]), .in_range(rd_ok[i])
    );
  end

  // Single RAM write port, shared by the pixel writer and the clear engine.
  always_comb begin
    clr_addr  = (front_q ? AW'(0) : AW'(NPIX)) + AW'(cnt_q);
    mem_we    = 1'b0;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = clr_color_q;
    end else if (wr_en && wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_ok[i]) rd_data_d[i*PIX_W +: PIX_W] = mem[rd_addr[i]];
    end
  end

  // A swap seen during a clear (or alongside clr_req) is held in pending_q
  // and applied on the same edge the final clear write lands.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_color_d = clr_color_q;
    front_d     = front_q;
    pending_d   = pending_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          clr_color_d = clr_color;
          pending_d   = swap_req;
          done_d      = (NPIX == 1);
        end else if (swap_req) begin
          front_d = ~front_q;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
          if (pending_q || swap_req) front_d = ~front_q;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          done_d = ((cnt_q + CW'(1)) == LAST);
          if (swap_req) pending_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      clr_color_q <= '0;
      front_q     <= 1'b0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_color_q <= clr_color_d;
      front_q     <= front_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = (state_q == ST_CLEAR);
  assign clr_done  = done_q;
  assign front_sel = front_q;

endmodule

// File: tb/tb_frame_buffer_db.sv
// Directed bench for frame_buffer_db: writes, range gating, clear/swap
// interaction, dual read ports and reset during a clear.
module tb_frame_buffer_db;

  localparam int XW = 7;
  localparam int YW = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [6:0]  wr_x = '0;
  logic [5:0]  wr_y = '0;
  logic [2:0]  wr_data = '0;
  logic        clr_req = 1'b0;
  logic [2:0]  clr_color = '0;
  logic        swap_req = 1'b0;
  logic [13:0] rd_x = '0;
  logic [11:0] rd_y = '0;
  logic [5:0]  rd_data;
  logic        busy;
  logic        clr_done;
  logic        front_sel;

  int n_cmp = 0;
  int n_bad = 0;

  frame_buffer_db dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .clr_req(clr_req), .clr_color(clr_color),
    .swap_req(swap_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .busy(busy), .clr_done(clr_done), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int x, input int y, input int c);
    wr_en = 1'b1; wr_x = 7'(x); wr_y = 6'(y); wr_data = 3'(c);
    step();
    wr_en = 1'b0;
  endtask

  task automatic set_rd(input int x0, input int y0, input int x1, input int y1);
    rd_x = {7'(x1), 7'(x0)};
    rd_y = {6'(y1), 6'(y0)};
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (front_sel !== 1'b0) begin n_bad++; $display("FAIL reset_front: got %0d want 0", front_sel); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0d want 0", busy); end
    n_cmp++; if (clr_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0d want 0", clr_done); end
    n_cmp++; if (rd_data !== 6'd0) begin n_bad++; $display("FAIL reset_rd: got %0d want 0", rd_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_swap();
    write_px(5, 3, 6);
    write_px(0, 0, 1);
    do_swap();
    n_cmp++; if (front_sel !== 1'b1) begin n_bad++; $display("FAIL ws_front: got %0d want 1", front_sel); end
    set_rd(5, 3, 0, 0);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd6) begin n_bad++; $display("FAIL ws_rd0: got %0d want 6", rd_data[2:0]); end
    n_cmp++; if (rd_data[5:3] !== 3'd1) begin n_bad++; $display("FAIL ws_rd1: got %0d want 1", rd_data[5:3]); end
  endtask

  // Back bank is 0 here; unchecked (0,60) in bank 0 would alias bank 1 (0,0)
  // and (120,0) would alias (0,1).
  task automatic test_out_of_range();
    write_px(0, 1, 4);
    write_px(120, 0, 7);
    write_px(0, 60, 7);
    set_rd(0, 0, 120, 0);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd1) begin n_bad++; $display("FAIL oor_alias_front: got %0d want 1", rd_data[2:0]); end
    n_cmp++; if (rd_data[5:3] !== 3'd0) begin n_bad++; $display("FAIL oor_rd_x: got %0d want 0", rd_data[5:3]); end
    do_swap();
    set_rd(0, 1, 120, 0);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd4) begin n_bad++; $display("FAIL oor_alias_back: got %0d want 4", rd_data[2:0]); end
    n_cmp++; if (rd_data[5:3] !== 3'd0) begin n_bad++; $display("FAIL oor_rd_gate: got %0d want 0", rd_data[5:3]); end
    set_rd(0, 60, 0, 0);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd0) begin n_bad++; $display("FAIL oor_rd_y: got %0d want 0", rd_data[2:0]); end
  endtask

  task automatic test_clear_swap();
    int busy_cnt, done_cnt, done_at, front_bad, cyc;
    busy_cnt = 0; done_cnt = 0; done_at = -1; front_bad = 0; cyc = 0;
    clr_req = 1'b1; clr_color = 3'd2;
    step();
    clr_req = 1'b0;
    while (busy === 1'b1 && cyc < 8000) begin
      busy_cnt++;
      if (clr_done === 1'b1) begin done_cnt++; done_at = cyc; end
      if (front_sel !== 1'b0) front_bad++;
      swap_req = (cyc == 100 || cyc == 200);
      wr_en = (cyc == 300); wr_x = 7'd10; wr_y = 6'd10; wr_data = 3'd5;
      clr_req = (cyc == 400); clr_color = 3'd5;
      step();
      cyc++;
    end
    swap_req = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    n_cmp++; if (busy_cnt !== 7200) begin n_bad++; $display("FAIL clr_busy_len: got %0d want 7200", busy_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL clr_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (done_at !== 7199) begin n_bad++; $display("FAIL clr_done_at: got %0d want 7199", done_at); end
    n_cmp++; if (front_bad !== 0) begin n_bad++; $display("FAIL clr_front_held: got %0d want 0", front_bad); end
    n_cmp++; if (front_sel !== 1'b1) begin n_bad++; $display("FAIL clr_front_swap: got %0d want 1", front_sel); end
    step();
    n_cmp++; if (front_sel !== 1'b1) begin n_bad++; $display("FAIL clr_single_swap: got %0d want 1", front_sel); end
    set_rd(0, 0, 119, 59);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd2) begin n_bad++; $display("FAIL clr_px_0_0: got %0d want 2", rd_data[2:0]); end
    n_cmp++; if (rd_data[5:3] !== 3'd2) begin n_bad++; $display("FAIL clr_px_119_59: got %0d want 2", rd_data[5:3]); end
    set_rd(10, 10, 5, 3);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd2) begin n_bad++; $display("FAIL clr_wr_ignored: got %0d want 2", rd_data[2:0]); end
    n_cmp++; if (rd_data[5:3] !== 3'd2) begin n_bad++; $display("FAIL clr_px_5_3: got %0d want 2", rd_data[5:3]); end
  endtask

  task automatic test_dual_read();
    write_px(7, 8, 3);
    write_px(100, 50, 5);
    do_swap();
    set_rd(7, 8, 100, 50);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd3) begin n_bad++; $display("FAIL dual_a0: got %0d want 3", rd_data[2:0]); end
    n_cmp++; if (rd_data[5:3] !== 3'd5) begin n_bad++; $display("FAIL dual_a1: got %0d want 5", rd_data[5:3]); end
    set_rd(100, 50, 7, 8);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd5) begin n_bad++; $display("FAIL dual_b0: got %0d want 5", rd_data[2:0]); end
    n_cmp++; if (rd_data[5:3] !== 3'd3) begin n_bad++; $display("FAIL dual_b1: got %0d want 3", rd_data[5:3]); end
  endtask

  task automatic test_write_with_swap();
    wr_en = 1'b1; wr_x = 7'd1; wr_y = 6'd1; wr_data = 3'd6;
    swap_req = 1'b1;
    step();
    wr_en = 1'b0; swap_req = 1'b0;
    n_cmp++; if (front_sel !== 1'b1) begin n_bad++; $display("FAIL wsw_front: got %0d want 1", front_sel); end
    set_rd(0, 0, 1, 1);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd2) begin n_bad++; $display("FAIL wsw_old: got %0d want 2", rd_data[2:0]); end
    n_cmp++; if (rd_data[5:3] !== 3'd6) begin n_bad++; $display("FAIL wsw_new: got %0d want 6", rd_data[5:3]); end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt, cyc;
    clr_req = 1'b1; clr_color = 3'd7;
    step();
    clr_req = 1'b0;
    repeat (50) step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmc_busy_pre: got %0d want 1", busy); end
    rst = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmc_busy: got %0d want 0", busy); end
    n_cmp++; if (front_sel !== 1'b0) begin n_bad++; $display("FAIL rmc_front: got %0d want 0", front_sel); end
    n_cmp++; if (rd_data !== 6'd0) begin n_bad++; $display("FAIL rmc_rd: got %0d want 0", rd_data); end
    rst = 1'b0;
    step();
    clr_req = 1'b1; clr_color = 3'd4; swap_req = 1'b1;
    step();
    clr_req = 1'b0; swap_req = 1'b0;
    busy_cnt = 0; cyc = 0;
    while (busy === 1'b1 && cyc < 8000) begin
      busy_cnt++;
      step();
      cyc++;
    end
    n_cmp++; if (busy_cnt !== 7200) begin n_bad++; $display("FAIL rmc_restart_len: got %0d want 7200", busy_cnt); end
    n_cmp++; if (front_sel !== 1'b1) begin n_bad++; $display("FAIL rmc_pending_swap: got %0d want 1", front_sel); end
    set_rd(1, 1, 119, 59);
    step();
    n_cmp++; if (rd_data[2:0] !== 3'd4) begin n_bad++; $display("FAIL rmc_px_1_1: got %0d want 4", rd_data[2:0]); end
    n_cmp++; if (rd_data[5:3] !== 3'd4) begin n_bad++; $display("FAIL rmc_px_119_59: got %0d want 4", rd_data[5:3]); end
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_out_of_range();
    test_clear_swap();
    test_dual_read();
    test_write_with_swap();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
